// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI4 encodings, 4KB page geometry and FSM state encoding.
// Used by both the read and write masters.
package dma_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

   localparam int PAGE_BYTES = 4096;
   localparam int PAGE_WORDS = PAGE_BYTES / 4;
   localparam int WORDS_W    = 14;   // remaining-word counter, max 16383 words

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } dma_state_e;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: beats = min(words left, MAX_BURST, words left in the current 4KB page).
// Purely combinational; arlen is beats-1 and is meaningless when words is 0.
module dma_burst_calc
   import dma_pkg::*;
#(
   parameter int MAX_BURST = 16
) (
   input  logic [WORDS_W-1:0] words,
   input  logic [9:0]         page_word_offset,
   output logic [8:0]         beats,
   output logic [7:0]         arlen
);

   localparam logic [WORDS_W-1:0] MAX_WORDS = WORDS_W'(MAX_BURST);

   logic [10:0]        page_words_left;
   logic [WORDS_W-1:0] cap;

   always_comb begin
      page_words_left = 11'(PAGE_WORDS) - {1'b0, page_word_offset};
      cap = (words < MAX_WORDS) ? words : MAX_WORDS;
      if (WORDS_W'(page_words_left) < cap) begin
         cap = WORDS_W'(page_words_left);
      end
      beats = 9'(cap);
      arlen = 8'(beats - 9'd1);
   end

endmodule

// File: rtl/dma_axi4_read_master.sv
// DMA read-side AXI4 master: splits a byte-count transfer into 4KB-safe INCR bursts
// (one outstanding) and streams R beats into the data FIFO, pulsing read_done at the end.
module dma_axi4_read_master
   import dma_pkg::*;
#(
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 32,
   parameter int         MAX_BURST = 16,
   parameter logic [3:0] AXI_ID    = 4'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_read,
   input  logic [15:0]       r_size_data,
   input  logic [ADDR_W-1:0] raddr_reg,
   output logic              read_done,
   output logic              rd_error,
   output logic              busy,
   output logic [3:0]        m_axi_arid,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wdata,
   input  logic              fifo_full
);

   dma_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [WORDS_W-1:0] words_q, words_d;
   logic [8:0]         beat_q, len_q, calc_beats;
   logic [7:0]         arlen_q, calc_arlen;
   logic               rd_error_q;
   logic               start_ok, ar_fire, r_fire, last_beat, burst_end;

   assign start_ok  = (state_q == ST_IDLE) && start_read;
   assign ar_fire   = m_axi_arvalid && m_axi_arready;
   assign r_fire    = m_axi_rvalid && m_axi_rready;
   assign last_beat = ((beat_q + 9'd1) == len_q);
   assign burst_end = r_fire && last_beat;

   // Next address/word count; the burst calculator looks at these so the new
   // arlen can be registered on the same edge that enters ADDR.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      addr_d  = addr_q;
      words_d = words_q;
      if (start_ok) begin
         addr_d  = raddr_reg & ~ADDR_W'(3);
         words_d = WORDS_W'(r_size_data >> 2);
      end else if (r_fire) begin
         words_d = words_q - WORDS_W'(1);
         if (last_beat) begin
            addr_d = addr_q + ADDR_W'({len_q, 2'b00});
         end
      end
   end

   dma_burst_calc #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_calc (
      .words            (words_d),
      .page_word_offset (addr_d[11:2]),
      .beats            (calc_beats),
      .arlen            (calc_arlen)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start_read)    state_d = (words_d == '0) ? ST_DONE : ST_ADDR;
         ST_ADDR: if (m_axi_arready) state_d = ST_DATA;
         ST_DATA: if (burst_end)     state_d = (words_d == '0) ? ST_DONE : ST_ADDR;
         ST_DONE:                    state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decode the state register directly, so an async reset drops them at once.
   always_comb begin
      m_axi_arvalid = (state_q == ST_ADDR);
      m_axi_rready  = (state_q == ST_DATA) && !fifo_full;
      read_done     = (state_q == ST_DONE);
      busy          = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         words_q    <= '0;
         beat_q     <= '0;
         len_q      <= '0;
         arlen_q    <= '0;
         rd_error_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         words_q <= words_d;
         if ((state_d == ST_ADDR) && (state_q != ST_ADDR)) begin
            len_q   <= calc_beats;
            arlen_q <= calc_arlen;
         end
         if (ar_fire) begin
            beat_q <= '0;
         end else if (r_fire) begin
            beat_q <= beat_q + 9'd1;
         end
         // The beat count ends the burst; rlast and rresp only raise the sticky error.
         if (start_ok) begin
            rd_error_q <= 1'b0;
         end else if (r_fire && ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat))) begin
            rd_error_q <= 1'b1;
         end
      end
   end

   assign rd_error      = rd_error_q;
   assign m_axi_arid    = AXI_ID;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = AXI_SIZE_4B;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign fifo_wr_en    = r_fire;
   assign fifo_wdata    = m_axi_rdata;

endmodule

// File: tb/tb_dma_axi4_read_master.sv
// Directed bench for dma_axi4_read_master: small AXI read slave (data = f(address)),
// AR/FIFO logging, and hand-computed expectations per transfer.
module tb_dma_axi4_read_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_read;
   logic [15:0] r_size_data;
   logic [31:0] raddr_reg;
   logic        read_done, rd_error, busy;
   logic [3:0]  m_axi_arid;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic        fifo_wr_en;
   logic [31:0] fifo_wdata;
   logic        fifo_full;

   always #5 clk = ~clk;

   dma_axi4_read_master dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_read    (start_read),
      .r_size_data   (r_size_data),
      .raddr_reg     (raddr_reg),
      .read_done     (read_done),
      .rd_error      (rd_error),
      .busy          (busy),
      .m_axi_arid    (m_axi_arid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_wdata    (fifo_wdata),
      .fifo_full     (fifo_full)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // Logs filled by the slave loop
   logic [31:0] ar_addr_q[$];
   logic [7:0]  ar_len_q[$];
   logic [31:0] push_q[$];
   int          done_cnt;
   int          arvalid_seen;
   int          err_beat;
   int          full_at_push;

   task automatic clear_log();
      ar_addr_q.delete();
      ar_len_q.delete();
      push_q.delete();
      done_cnt     = 0;
      arvalid_seen = 0;
   endtask

   // Slave: drives at negedge, samples the upcoming-posedge handshakes 1ns later.
   initial begin : slave
      logic        r_active, ar_acc, r_acc;
      logic [31:0] r_addr, acc_addr;
      int          r_left, full_left;
      logic [7:0]  acc_len;
      r_active = 1'b0; ar_acc = 1'b0; r_acc = 1'b0;
      r_addr = '0; acc_addr = '0; acc_len = '0; r_left = 0; full_left = 0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
      m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; fifo_full = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            r_active = 1'b0; ar_acc = 1'b0; r_acc = 1'b0; full_left = 0;
            m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; fifo_full = 1'b0;
         end else begin
            if (ar_acc) begin
               r_active = 1'b1;
               r_addr   = acc_addr;
               r_left   = int'(acc_len) + 1;
            end
            if (r_acc) begin
               r_addr = r_addr + 32'd4;
               r_left--;
               if (r_left == 0) r_active = 1'b0;
            end
            ar_acc = 1'b0;
            r_acc  = 1'b0;
            if (full_left == 0 && full_at_push >= 0 && push_q.size() >= full_at_push) begin
               full_left    = 5;
               full_at_push = -1;
            end
            fifo_full     = (full_left > 0);
            m_axi_arready = 1'b1;
            m_axi_rvalid  = r_active;
            m_axi_rdata   = data_of(r_addr);
            m_axi_rlast   = r_active && (r_left == 1);
            m_axi_rresp   = (push_q.size() == err_beat) ? 2'b10 : 2'b00;
         end
         #1;
         if (rst_n) begin
            if (m_axi_arvalid && m_axi_arready) begin
               ar_acc   = 1'b1;
               acc_addr = m_axi_araddr;
               acc_len  = m_axi_arlen;
               ar_addr_q.push_back(m_axi_araddr);
               ar_len_q.push_back(m_axi_arlen);
            end
            if (m_axi_rvalid && m_axi_rready) r_acc = 1'b1;
            if (fifo_wr_en) push_q.push_back(fifo_wdata);
            if (read_done) done_cnt++;
            if (m_axi_arvalid) arvalid_seen++;
            if (fifo_full) begin
               check("full_rready", 64'(m_axi_rready), 64'd0);
               check("full_push", 64'(fifo_wr_en), 64'd0);
            end
            if (full_left > 0) full_left--;
         end
      end
   end

   task automatic start_xfer(input logic [31:0] a, input logic [15:0] s);
      @(negedge clk);
      raddr_reg   = a;
      r_size_data = s;
      start_read  = 1'b1;
      @(negedge clk);
      start_read  = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 1000 && done_cnt == 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_ar(input int idx, input logic [31:0] a, input logic [7:0] len);
      if (idx < ar_addr_q.size()) begin
         check($sformatf("ar%0d_addr", idx), 64'(ar_addr_q[idx]), 64'(a));
         check($sformatf("ar%0d_len", idx), 64'(ar_len_q[idx]), 64'(len));
      end else begin
         check($sformatf("ar%0d_present", idx), 64'(ar_addr_q.size()), 64'(idx + 1));
      end
   endtask

   task automatic check_pushes(input logic [31:0] base, input int n);
      check("push_cnt", 64'(push_q.size()), 64'(n));
      for (int i = 0; i < n && i < push_q.size(); i++) begin
         check($sformatf("push%0d", i), 64'(push_q[i]), 64'(data_of(base + 32'(i * 4))));
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      rst_n = 1'b0; start_read = 1'b0; raddr_reg = '0; r_size_data = '0;
      err_beat = -1; full_at_push = -1;
      clear_log();
      repeat (3) @(negedge clk);
      #1;
      check("rst_done", 64'(read_done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("rst_rready", 64'(m_axi_rready), 64'd0);
      check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
      check("rst_araddr", 64'(m_axi_araddr), 64'd0);
      check("rst_arlen", 64'(m_axi_arlen), 64'd0);
      check("rst_error", 64'(rd_error), 64'd0);
      check("arsize", 64'(m_axi_arsize), 64'd2);
      check("arburst", 64'(m_axi_arburst), 64'd1);
      check("arid", 64'(m_axi_arid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single 4-beat burst
      clear_log();
      start_xfer(32'hA000_0000, 16'd16);
      #1 check("t1_busy", 64'(busy), 64'd1);
      wait_done();
      check("t1_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
      check_ar(0, 32'hA000_0000, 8'd3);
      check_pushes(32'hA000_0000, 4);
      check("t1_done", 64'(done_cnt), 64'd1);
      check("t1_err", 64'(rd_error), 64'd0);
      check("t1_busy_end", 64'(busy), 64'd0);

      // 2: two full bursts; a start while busy is ignored
      clear_log();
      start_xfer(32'hA000_0000, 16'd128);
      repeat (5) @(negedge clk);
      start_xfer(32'h1234_0000, 16'd4);
      wait_done();
      check("t2_ar_cnt", 64'(ar_addr_q.size()), 64'd2);
      check_ar(0, 32'hA000_0000, 8'd15);
      check_ar(1, 32'hA000_0040, 8'd15);
      check_pushes(32'hA000_0000, 32);
      check("t2_done", 64'(done_cnt), 64'd1);

      // 3: 4KB split
      clear_log();
      start_xfer(32'hA000_0FF0, 16'd32);
      wait_done();
      check("t3_ar_cnt", 64'(ar_addr_q.size()), 64'd2);
      check_ar(0, 32'hA000_0FF0, 8'd3);
      check_ar(1, 32'hA000_1000, 8'd3);
      check_pushes(32'hA000_0FF0, 8);
      check("t3_done", 64'(done_cnt), 64'd1);

      // 4: FIFO full for 5 cycles after 3 pushes
      clear_log();
      full_at_push = 3;
      start_xfer(32'hB000_0000, 16'd64);
      wait_done();
      check("t4_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
      check_ar(0, 32'hB000_0000, 8'd15);
      check_pushes(32'hB000_0000, 16);
      check("t4_done", 64'(done_cnt), 64'd1);
      check("t4_err", 64'(rd_error), 64'd0);

      // 5a: zero-length transfer
      clear_log();
      start_xfer(32'hA000_0000, 16'd3);
      #1 check("t5_done_pulse", 64'(read_done), 64'd1);
      check("t5_busy", 64'(busy), 64'd1);
      @(negedge clk);
      #1 check("t5_done_drop", 64'(read_done), 64'd0);
      repeat (2) @(negedge clk);
      check("t5_done_cnt", 64'(done_cnt), 64'd1);
      check("t5_no_arvalid", 64'(arvalid_seen), 64'd0);
      check("t5_no_push", 64'(push_q.size()), 64'd0);

      // 5b: SLVERR on second beat
      clear_log();
      err_beat = 1;
      start_xfer(32'hA000_0100, 16'd16);
      wait_done();
      err_beat = -1;
      check_pushes(32'hA000_0100, 4);
      check("t5b_err", 64'(rd_error), 64'd1);
      check("t5b_done", 64'(done_cnt), 64'd1);

      // 6: reset during DATA, then a clean transfer
      clear_log();
      start_xfer(32'hC000_0000, 16'd64);
      #1 check("t6_err_cleared", 64'(rd_error), 64'd0);
      for (int i = 0; i < 200 && push_q.size() < 3; i++) @(negedge clk);
      check("t6_reached_data", 64'(push_q.size() >= 3), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("t6_rst_rready", 64'(m_axi_rready), 64'd0);
      check("t6_rst_wr_en", 64'(fifo_wr_en), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_no_done", 64'(done_cnt), 64'd0);
      clear_log();
      start_xfer(32'hC000_1000, 16'd16);
      wait_done();
      check("t6_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
      check_ar(0, 32'hC000_1000, 8'd3);
      check_pushes(32'hC000_1000, 4);
      check("t6_done", 64'(done_cnt), 64'd1);
      check("t6_err", 64'(rd_error), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
